// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-client ALU arbiter: command codes, datapath width
// and sequencer state encoding.
package alu_arbiter_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_XOR  = 3'd2;
   localparam logic [2:0] ALU_SLT  = 3'd3;
   localparam logic [2:0] ALU_AND  = 3'd4;
   localparam logic [2:0] ALU_NAND = 3'd5;
   localparam logic [2:0] ALU_OR   = 3'd6;
   localparam logic [2:0] ALU_NOR  = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU shared by both clients of alu_arbiter.
// SUB and SLT reuse the adder as a + ~b + 1; carryout is the raw adder carry.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       cmd,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             add_ovf;

   always_comb begin
      sub     = (cmd == ALU_SUB) || (cmd == ALU_SLT);
      b_eff   = sub ? ~b : b;
      sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

   always_comb begin
      result   = '0;
      carryout = 1'b0;
      overflow = 1'b0;
      case (cmd)
         ALU_ADD, ALU_SUB: begin
            result   = sum[WIDTH-1:0];
            carryout = sum[WIDTH];
            overflow = add_ovf;
         end
         ALU_SLT: begin
            // Signed less-than: sign of the difference corrected by overflow.
            result   = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            carryout = sum[WIDTH];
            overflow = add_ovf;
         end
         ALU_XOR:  result = a ^ b;
         ALU_AND:  result = a & b;
         ALU_NAND: result = ~(a & b);
         ALU_OR:   result = a | b;
         ALU_NOR:  result = ~(a | b);
         default:  result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Handshake: a transfer occurs on a rising edge where valid and ready are both high.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter bit RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_cmd,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_cmd,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carryout,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   arb_state_e       state;
   logic             prio;
   logic             owner;
   logic [2:0]       op_cmd;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   logic [WIDTH-1:0] alu_result;
   logic             alu_carryout;
   logic             alu_overflow;
   logic             alu_zero;

   logic             grant0;
   logic             grant1;
   logic             rsp_taken;

   // prio names the requester that wins when both are valid.
   assign grant0 = req0_valid && (!req1_valid || !prio);
   assign grant1 = req1_valid && (!req0_valid ||  prio);

   assign req0_ready = (state == S_IDLE) && grant0 && !reset;
   assign req1_ready = (state == S_IDLE) && grant1 && !reset;

   assign rsp0_valid = (state == S_RESP) && !owner;
   assign rsp1_valid = (state == S_RESP) &&  owner;
   assign rsp_taken  = owner ? rsp1_ready : rsp0_ready;

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

   alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
      .cmd      (op_cmd),
      .a        (op_a),
      .b        (op_b),
      .result   (alu_result),
      .carryout (alu_carryout),
      .overflow (alu_overflow),
      .zero     (alu_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         prio         <= RR_INIT;
         owner        <= 1'b0;
         op_cmd       <= '0;
         op_a         <= '0;
         op_b         <= '0;
         rsp_result   <= '0;
         rsp_carryout <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant0) begin
                  op_cmd <= req0_cmd;
                  op_a   <= req0_a;
                  op_b   <= req0_b;
                  owner  <= 1'b0;
                  prio   <= 1'b1;
                  state  <= S_EXEC;
               end else if (grant1) begin
                  op_cmd <= req1_cmd;
                  op_a   <= req1_a;
                  op_b   <= req1_b;
                  owner  <= 1'b1;
                  prio   <= 1'b0;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_result   <= alu_result;
               rsp_carryout <= alu_carryout;
               rsp_overflow <= alu_overflow;
               rsp_zero     <= alu_zero;
               state        <= S_RESP;
            end
            S_RESP: begin
               if (rsp_taken) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with hand-computed expected results.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]   req0_cmd, req1_cmd;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_carryout, rsp_overflow, rsp_zero, busy;
   logic [1:0]   dbg_state;

   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   logic [W-1:0] exp_q[$];

   alu_arbiter #(.WIDTH(W), .RR_INIT(1'b0)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
      .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input int n, input logic v, input logic [2:0] cmd,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      if (n == 0) begin
         req0_valid = v; req0_cmd = cmd; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_cmd = cmd; req1_a = a; req1_b = b;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_req(0, 1'b0, 3'd0, '0, '0);
      drive_req(1, 1'b0, 3'd0, '0, '0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One full transaction on requester n, checking handshake timing and response.
   task automatic op(input string tag, input int n, input logic [2:0] cmd,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_r,
                     input logic exp_c, input logic exp_v, input logic exp_z);
      int   w;
      logic rdy, rv, ro;
      @(negedge clk);
      drive_req(n, 1'b1, cmd, a, b);
      #1;
      w = 0;
      rdy = (n == 0) ? req0_ready : req1_ready;
      while (!rdy && w < 20) begin
         @(negedge clk); #1; w++;
         rdy = (n == 0) ? req0_ready : req1_ready;
      end
      check({tag, "_accept"}, 32'(rdy), 32'd1);
      @(negedge clk);
      drive_req(n, 1'b0, 3'd0, '0, '0);
      #1;
      rv = (n == 0) ? rsp0_valid : rsp1_valid;
      check({tag, "_exec_rspv"}, 32'(rv), 32'd0);
      check({tag, "_exec_busy"}, 32'(busy), 32'd1);
      @(negedge clk); #1;
      rv = (n == 0) ? rsp0_valid : rsp1_valid;
      ro = (n == 0) ? rsp1_valid : rsp0_valid;
      check({tag, "_rspv"}, 32'(rv), 32'd1);
      check({tag, "_other_rspv"}, 32'(ro), 32'd0);
      check({tag, "_result"}, rsp_result, exp_r);
      check({tag, "_flags"}, {29'd0, rsp_carryout, rsp_overflow, rsp_zero},
            {29'd0, exp_c, exp_v, exp_z});
      if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      #1;
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int   grants, last;
      logic got;

      // 1: reset state, then single ADD on requester 0
      do_reset();
      #1;
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rspv", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      check("rst_result", rsp_result, 32'd0);
      check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      op("t1_add", 0, ALU_ADD, 32'h7fff_fffe, 32'h0000_0001, 32'h7fff_ffff, 1'b0, 1'b0, 1'b0);

      // 2: simultaneous requests after reset, requester 0 first
      do_reset();
      drive_req(0, 1'b1, ALU_SUB, 32'h7fff_ffff, 32'h7fff_ffff);
      drive_req(1, 1'b1, ALU_XOR, 32'haaaa_aaaa, 32'h5555_5555);
      #1;
      check("t2_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
      @(negedge clk);
      drive_req(0, 1'b0, 3'd0, '0, '0);
      #1;
      check("t2_exec_r1rdy", 32'(req1_ready), 32'd0);
      @(negedge clk); #1;
      check("t2_rsp0v", 32'(rsp0_valid), 32'd1);
      check("t2_sub_res", rsp_result, 32'h0000_0000);
      check("t2_sub_zero", 32'(rsp_zero), 32'd1);
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      check("t2_r1rdy", 32'(req1_ready), 32'd1);
      @(negedge clk);
      drive_req(1, 1'b0, 3'd0, '0, '0);
      @(negedge clk); #1;
      check("t2_rsp1v", {30'd0, rsp0_valid, rsp1_valid}, 32'd1);
      check("t2_xor_res", rsp_result, 32'hffff_ffff);
      check("t2_xor_zero", 32'(rsp_zero), 32'd0);
      rsp1_ready = 1'b1;
      @(negedge clk);
      rsp1_ready = 1'b0;

      // 3: response back-pressure with requester 1 waiting
      do_reset();
      drive_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
      drive_req(1, 1'b1, ALU_XOR, 32'h0000_00f0, 32'h0000_000f);
      @(negedge clk);
      drive_req(0, 1'b0, 3'd0, '0, '0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3_hold_v", 32'(rsp0_valid), 32'd1);
         check("t3_hold_res", rsp_result, 32'd3);
         check("t3_hold_r1rdy", 32'(req1_ready), 32'd0);
         check("t3_hold_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      check("t3_r1rdy", 32'(req1_ready), 32'd1);
      @(negedge clk);
      drive_req(1, 1'b0, 3'd0, '0, '0);
      @(negedge clk); #1;
      check("t3_rsp1v", 32'(rsp1_valid), 32'd1);
      check("t3_xor_res", rsp_result, 32'h0000_00ff);
      rsp1_ready = 1'b1;
      @(negedge clk);
      rsp1_ready = 1'b0;

      // 4: both requesters saturating, responses always taken
      do_reset();
      exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
      drive_req(1, 1'b1, ALU_ADD, 32'd5, 32'd5);
      grants = 0;
      last = 0;
      for (int c = 0; c < 30 && grants < 4; c++) begin
         #1;
         if (req0_ready || req1_ready) begin
            got = req1_ready;
            check("t4_onehot", 32'(req0_ready && req1_ready), 32'd0);
            check("t4_grant", 32'(got), exp_q.pop_front());
            if (grants > 0) check("t4_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            grants++;
         end
         if (rsp0_valid) check("t4_rsp0", rsp_result, 32'd2);
         if (rsp1_valid) check("t4_rsp1", rsp_result, 32'd10);
         @(negedge clk);
      end
      check("t4_grants", 32'(grants), 32'd4);
      drive_req(0, 1'b0, 3'd0, '0, '0);
      drive_req(1, 1'b0, 3'd0, '0, '0);
      repeat (3) @(negedge clk);
      #1;
      check("t4_drained", 32'(busy), 32'd0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;

      // 5: flag behaviour
      do_reset();
      op("t5_add_ovf", 0, ALU_ADD, 32'h7fff_fffe, 32'h0000_0002, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      op("t5_slt", 1, ALU_SLT, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
      op("t5_nand", 0, ALU_NAND, 32'h0000_0000, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);

      // 6: reset during EXEC, then during RESP
      do_reset();
      drive_req(0, 1'b1, ALU_ADD, 32'd3, 32'd4);
      @(negedge clk);
      drive_req(0, 1'b0, 3'd0, '0, '0);
      #1;
      check("t6_in_exec", 32'(dbg_state), 32'(S_EXEC));
      reset = 1'b1;
      #1;
      check("t6_exec_rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("t6_exec_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive_req(0, 1'b1, ALU_ADD, 32'd3, 32'd4);
      @(negedge clk);
      drive_req(0, 1'b0, 3'd0, '0, '0);
      @(negedge clk); #1;
      check("t6_in_resp", 32'(rsp0_valid), 32'd1);
      check("t6_resp_res", rsp_result, 32'd7);
      reset = 1'b1;
      #1;
      check("t6_resp_rst_v", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      check("t6_resp_rst_res", rsp_result, 32'd0);
      check("t6_resp_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive_req(0, 1'b1, ALU_OR, 32'h0000_0f00, 32'h0000_00f0);
      drive_req(1, 1'b1, ALU_AND, 32'hffff_ffff, 32'h1234_5678);
      #1;
      check("t6_prio_restored", {30'd0, req0_ready, req1_ready}, 32'd2);
      drive_req(1, 1'b0, 3'd0, '0, '0);
      @(negedge clk);
      drive_req(0, 1'b0, 3'd0, '0, '0);
      @(negedge clk); #1;
      check("t6_fresh_v", 32'(rsp0_valid), 32'd1);
      check("t6_fresh_res", rsp_result, 32'h0000_0ff0);
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      op("t6_after", 1, ALU_NOR, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #200000;
      miscompares++;
      $display("FAIL timeout: got running expected finished");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester, round-robin arbiter and sequencer that shares one 32-bit ALU instance between two clients. Each client submits an operation (command, a, b) with a valid/ready handshake. The block registers the operands, runs one ALU evaluation, and returns the result plus flags to the winning client with a valid/ready response handshake. It sits between client control logic (e.g. a multi-cycle CPU datapath and an address/branch unit) and the shared ALU.

Parameters:
WIDTH, 32, operand/result width; fixed to match the ALU, not intended to be overridden.
RR_INIT, 0, requester given priority after reset (0 or 1).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_cmd  input  3  ALU command for requester 0
req0_a  input  WIDTH  operand a for requester 0
req0_b  input  WIDTH  operand b for requester 0
req1_valid, req1_ready, req1_cmd, req1_a, req1_b  same as above, requester 1
rsp0_valid  output  1  response for requester 0 is valid
rsp0_ready  input  1  requester 0 takes the response
rsp1_valid  output  1  response for requester 1 is valid
rsp1_ready  input  1  requester 1 takes the response
rsp_result  output  WIDTH  shared response data: ALU result
rsp_carryout  output  1  shared response flag: carryout
rsp_overflow  output  1  shared response flag: signed overflow
rsp_zero  output  1  shared response flag: result == 0
busy  output  1  high in any state except IDLE

Behaviour:
- Command encoding: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 OR, 7 NOR. Passed unmodified to the ALU.
- States: IDLE, EXEC, RESP. Encoding is 2 bits.
- Reset (async): state=IDLE, prio=RR_INIT. Operand, command and response registers are cleared to 0. All req*_ready, rsp*_valid and busy are 0.
- IDLE:
  - If neither request is valid, stay in IDLE.
  - If only one request is valid, grant it.
  - If both are valid, grant the requester indicated by prio.
  - reqN_ready is combinational: (state==IDLE) && grantN. It is asserted for exactly one cycle, and the accept happens on that edge.
  - On accept: capture cmd/a/b into the operand registers, owner<=N, prio<=~N, go to EXEC.
- EXEC:
  - The ALU is driven only from the operand registers.
  - At the end of the cycle, capture result/carryout/overflow/zero into the response registers and go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid is 0.
  - Response data is held stable until rsp<owner>_ready=1, then go to IDLE.
  - No new request is accepted during the RESP cycle, including the cycle in which the response is taken.
- Latency and throughput:
  - Accept on edge N; rsp valid is high from N+2.
  - A new accept is possible at the earliest 1 cycle after the response is taken, so the minimum is 3 cycles per op.
- The unused rsp valid is 0. The shared rsp data bus is valid only while a rsp valid is high.
- Requester obligations:
  - A requester must hold valid/cmd/a/b stable until ready.
  - reqN_valid may drop without acceptance; nothing is captured in that case.
- rsp ready while the corresponding valid=0: ignored.
- Flag semantics come from the ALU and are not re-derived:
  - carryout/overflow are meaningful for ADD/SUB/SLT.
  - zero reflects the full WIDTH-bit result.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response. The requester must re-issue.
- prio changes only on accept, never on response.

Decomposition:
- Shared header alu_defs: command constants (ALU_ADD..ALU_NOR), WIDTH, state encodings.
- Sub-module: one instance of the existing ALU, fed from the operand registers.
- Grant/priority logic stays inline; it is too small to warrant a separate module.

Test Plan:
1. After reset, req0 only, ADD a=7ffffffe b=00000001 -> req0_ready for 1 cycle; 2 cycles later rsp0_valid=1, rsp_result=7fffffff, carryout=0, overflow=0, zero=0; rsp1_valid stays 0.
2. Both valid in the same cycle after reset: req0 SUB 7fffffff-7fffffff, req1 XOR aaaaaaaa^55555555 -> req0 served first (result 00000000, zero=1), then req1 (result ffffffff, zero=0).
3. Back-pressure: hold rsp0_ready=0 for 5 cycles with req1_valid=1 -> rsp0_valid and rsp_result stay stable, req1_ready stays 0, busy=1; req1 is accepted 1 cycle after rsp0_ready is asserted.
4. Both requesters continuously valid, with rsp ready tied high, for 4 ops -> grants alternate 0,1,0,1 and each op takes 3 cycles.
5. Flag checks, one op each: ADD 7ffffffe+00000002 -> result 80000000, overflow=1. SLT a=ffffffff b=00000001 -> result 00000001. NAND 00000000,ffffffff -> result ffffffff.
6. Assert reset during EXEC, then during RESP -> outputs go to 0 immediately; after release, state is IDLE, prio=RR_INIT, and a fresh request completes normally.
